// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD sequencer:
// FSM states, byte payload, command codes and the power-up init ROM.
package lcd_pkg;

  localparam int unsigned INIT_LEN  = 5;
  localparam int unsigned ROM_IDX_W = 3;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_WAIT,
    ST_IDLE
  } lcd_state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic logic [7:0] init_rom(input logic [ROM_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return CMD_FUNC_8B2L;
      3'd1:    return CMD_FUNC_8B2L;
      3'd2:    return CMD_DISP_ON;
      3'd3:    return CMD_CLEAR;
      default: return CMD_ENTRY_INC;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input lcd_byte_t b);
    return (!b.rs) && (b.data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done_c flags the last cycle of a loaded interval
// so that a load of N keeps the owning state active for exactly N cycles.
module lcd_delay_counter #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 LCD write sequencer: power-up wait, fixed init sequence, then
// host bytes with setup / enable-pulse / execution-wait timing.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter int unsigned PWRUP_WAIT_CYC = 750000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       ref_clk_clk,
  input  logic       ref_reset_reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       bl_en,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon
);

  if (SETUP_CYC < 1 || EN_HIGH_CYC < 1 || CMD_WAIT_CYC < 1 ||
      CLEAR_WAIT_CYC < 1 || PWRUP_WAIT_CYC < 1) begin : g_bad_zero
    $error("lcd_hd44780_ctrl: all timing parameters must be >= 1");
  end
  if ((64'(PWRUP_WAIT_CYC) >> CNT_W) != 0 || (64'(CLEAR_WAIT_CYC) >> CNT_W) != 0 ||
      (64'(CMD_WAIT_CYC) >> CNT_W) != 0) begin : g_bad_width
    $error("lcd_hd44780_ctrl: CNT_W too small for the configured waits");
  end

  lcd_state_t               state, next_state;
  lcd_byte_t                byte_q, byte_d;
  logic [ROM_IDX_W-1:0]     rom_idx, rom_idx_d;
  logic                     init_done_d;
  logic                     cnt_load;
  logic [CNT_W-1:0]         cnt_val;
  logic                     cnt_done_c;
  logic                     accept_c;

  assign accept_c = (state == ST_IDLE) && wr_valid && wr_ready;

  lcd_delay_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (PWRUP_WAIT_CYC)
  ) u_delay (
    .clk      (ref_clk_clk),
    .rst      (ref_reset_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done_c   (cnt_done_c)
  );

  // State and registered outputs.
  always_ff @(posedge ref_clk_clk or posedge ref_reset_reset) begin
    if (ref_reset_reset) begin
      state     <= ST_PWRUP;
      byte_q    <= '0;
      rom_idx   <= '0;
      init_done <= 1'b0;
      lcd_en    <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b1;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
    end else begin
      state     <= next_state;
      byte_q    <= byte_d;
      rom_idx   <= rom_idx_d;
      init_done <= init_done_d;
      lcd_en    <= (next_state == ST_EN_HI);
      wr_ready  <= (next_state == ST_IDLE);
      busy      <= (next_state != ST_IDLE);
      lcd_on    <= 1'b1;
      lcd_blon  <= bl_en;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_PWRUP: if (cnt_done_c) next_state = ST_INIT;
      ST_INIT:  next_state = ST_SETUP;
      ST_LOAD:  next_state = ST_SETUP;
      ST_SETUP: if (cnt_done_c) next_state = ST_EN_HI;
      ST_EN_HI: if (cnt_done_c) next_state = ST_WAIT;
      ST_WAIT: begin
        if (cnt_done_c) begin
          if (!init_done && rom_idx != ROM_IDX_W'(INIT_LEN - 1)) next_state = ST_INIT;
          else                                                  next_state = ST_IDLE;
        end
      end
      ST_IDLE:  if (accept_c) next_state = ST_LOAD;
      default:  next_state = ST_PWRUP;
    endcase
  end

  // Counter loads and datapath updates; the LOAD state gives host bytes the
  // same one-cycle lead-in that INIT gives ROM bytes.
  always_comb begin
    cnt_load    = 1'b0;
    cnt_val     = '0;
    byte_d      = byte_q;
    rom_idx_d   = rom_idx;
    init_done_d = init_done;
    case (state)
      ST_INIT: begin
        byte_d   = '{rs: 1'b0, data: init_rom(rom_idx)};
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SETUP_CYC);
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SETUP_CYC);
      end
      ST_SETUP: begin
        if (cnt_done_c) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(EN_HIGH_CYC);
        end
      end
      ST_EN_HI: begin
        if (cnt_done_c) begin
          cnt_load = 1'b1;
          cnt_val  = is_slow_cmd(byte_q) ? CNT_W'(CLEAR_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);
        end
      end
      ST_WAIT: begin
        if (cnt_done_c && !init_done) begin
          if (rom_idx == ROM_IDX_W'(INIT_LEN - 1)) init_done_d = 1'b1;
          else                                    rom_idx_d   = rom_idx + ROM_IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept_c) byte_d = '{rs: wr_rs, data: wr_data};
      end
      default: ;
    endcase
  end

  assign lcd_data = byte_q.data;
  assign lcd_rs   = byte_q.rs;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed self-checking bench for lcd_hd44780_ctrl with shortened timing:
// init sequence, host writes, held-valid during init, mid-pulse reset, backlight.
module tb_lcd_hd44780_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       bl_en = 1'b0;
  logic       init_done;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_on;
  logic       lcd_blon;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rw_bad = 0;
  int blon_bad = 0;
  logic bl_sample;

  logic [7:0] rom_exp [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         wait_exp [5] = '{10, 10, 10, 40, 10};

  lcd_hd44780_ctrl #(
    .SETUP_CYC      (2),
    .EN_HIGH_CYC    (3),
    .CMD_WAIT_CYC   (10),
    .CLEAR_WAIT_CYC (40),
    .PWRUP_WAIT_CYC (20),
    .CNT_W          (20)
  ) dut (
    .ref_clk_clk     (clk),
    .ref_reset_reset (rst),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_rs           (wr_rs),
    .wr_data         (wr_data),
    .bl_en           (bl_en),
    .init_done       (init_done),
    .busy            (busy),
    .lcd_data        (lcd_data),
    .lcd_en          (lcd_en),
    .lcd_rs          (lcd_rs),
    .lcd_rw          (lcd_rw),
    .lcd_on          (lcd_on),
    .lcd_blon        (lcd_blon)
  );

  always #5 clk = ~clk;

  // Backlight reference: bl_en one edge late, held low through reset.
  always @(posedge clk or posedge rst) begin
    if (rst) bl_sample <= 1'b0;
    else     bl_sample <= bl_en;
  end

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (lcd_blon !== bl_sample) blon_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bl_en = ((cyc / 7) % 2 == 1);
  endtask

  task automatic wait_en(input logic lvl, input int budget);
    int n = 0;
    while (lcd_en !== lvl && n < budget) begin step(); n++; end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (wr_ready !== 1'b1 && n < budget) begin step(); n++; end
  endtask

  task automatic en_width(input string tag);
    int n = 0;
    while (lcd_en === 1'b1 && n < 10) begin step(); n++; end
    chk({tag, "_en_width"}, 32'(n), 32'd3);
  endtask

  task automatic no_pulses(input string tag, input int ncyc);
    int rises = 0;
    logic prev;
    prev = lcd_en;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (lcd_en === 1'b1 && prev !== 1'b1) rises++;
      prev = lcd_en;
    end
    chk({tag, "_extra_en"}, 32'(rises), 32'd0);
  endtask

  // Called right after reset release; first step is the lcd_on edge.
  task automatic check_init(input string tag);
    int ref_c, rise_c, fall_c;
    step();
    chk({tag, "_lcd_on"}, 32'(lcd_on), 32'd1);
    chk({tag, "_en_low"}, 32'(lcd_en), 32'd0);
    chk({tag, "_ready_low"}, 32'(wr_ready), 32'd0);
    ref_c  = cyc;
    fall_c = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_en(1'b1, 100);
      rise_c = cyc;
      if (k == 0) chk({tag, "_first_en"}, 32'(rise_c - ref_c), 32'd22);
      else        chk({tag, "_gap"}, 32'(rise_c - fall_c), 32'(wait_exp[k-1] + 3));
      chk({tag, "_rom_data"}, 32'(lcd_data), 32'(rom_exp[k]));
      chk({tag, "_rom_rs"}, 32'(lcd_rs), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      en_width(tag);
      fall_c = cyc;
    end
    wait_ready(100);
    chk({tag, "_ready_lat"}, 32'(cyc - fall_c), 32'd10);
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic host_byte(input logic rs, input logic [7:0] d, input int wt, input string tag);
    int acc, bad, n;
    wait_ready(200);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    step();
    acc = cyc;
    chk({tag, "_ready_drop"}, 32'(wr_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wr_valid = 1'b0;
    wr_rs    = ~rs;
    wr_data  = ~d;
    wait_en(1'b1, 20);
    chk({tag, "_en_lat"}, 32'(cyc - acc), 32'd3);
    chk({tag, "_data"}, 32'(lcd_data), 32'(d));
    chk({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
    en_width(tag);
    bad = 0;
    n   = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      if (lcd_data !== d || lcd_rs !== rs) bad++;
      step();
      n++;
    end
    chk({tag, "_hold"}, 32'(bad), 32'd0);
    chk({tag, "_ready_lat"}, 32'(cyc - acc), 32'(6 + wt));
  endtask

  initial begin
    // Host byte held valid throughout reset and init.
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h31;
    bl_en    = 1'b1;
    step();
    chk("rst_en", 32'(lcd_en), 32'd0);
    chk("rst_on", 32'(lcd_on), 32'd0);
    chk("rst_blon", 32'(lcd_blon), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    step();
    rst = 1'b0;
    check_init("init");

    host_byte(1'b1, 8'h31, 10, "held");
    no_pulses("held_once", 30);

    host_byte(1'b1, 8'h41, 10, "chr41");
    host_byte(1'b0, 8'h02, 40, "home");
    host_byte(1'b1, 8'h02, 10, "chr02");
    host_byte(1'b0, 8'h03, 40, "home3");
    host_byte(1'b0, 8'h04, 10, "entry04");
    host_byte(1'b0, 8'h01, 40, "clear");

    // Reset in the middle of the enable pulse of a host byte.
    wait_ready(200);
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h5A;
    step();
    wr_valid = 1'b0;
    wait_en(1'b1, 20);
    step();
    chk("mid_en_before", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(lcd_en), 32'd0);
    chk("mid_rst_on", 32'(lcd_on), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    chk("mid_rst_data", 32'(lcd_data), 32'd0);
    step();
    step();
    rst = 1'b0;
    check_init("reinit");
    no_pulses("dropped", 30);

    chk("rw_low", 32'(rw_bad), 32'd0);
    chk("blon_follow", 32'(blon_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
